// File: rtl/approx_mul_share_ctrl_pkg.sv
// Shared constants and golden arithmetic for the shared 8x8 approximate multiplier.
// The exact-product helper is used only when APPROX_MUL_EXACT_EN is defined.
package approx_mul_pkg;

  localparam int unsigned L               = 2;
  localparam int unsigned DEFAULT_NUM_REQ = 4;
  localparam int unsigned OP_W            = 8;
  localparam int unsigned PROD_W          = 16;

  // Truncate the low L multiplicand bits, then add back a single compensation term.
  function automatic logic [PROD_W-1:0] approx_mul8_l2(input logic [OP_W-1:0] x,
                                                       input logic [OP_W-1:0] y);
    logic [PROD_W-1:0] trunc_prod;
    logic [PROD_W-1:0] comp;
    trunc_prod = (PROD_W'(x >> L) * PROD_W'(y)) << L;
    comp       = PROD_W'(x[L-1] & y[OP_W-1]) << 8;
    return trunc_prod + comp;
  endfunction

  function automatic logic [PROD_W-1:0] exact_mul8(input logic [OP_W-1:0] x,
                                                   input logic [OP_W-1:0] y);
    return PROD_W'(x) * PROD_W'(y);
  endfunction

endpackage

// File: rtl/approx_mul_share_ctrl_if.sv
// Requester/response bus for approx_mul_share_ctrl.
// APPROX_MUL_EXACT_EN adds the req_exact / rsp_exact sideband.
interface approx_mul_share_ctrl_if
  import approx_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [OP_W*NUM_REQ-1:0] req_x;
  logic [OP_W*NUM_REQ-1:0] req_y;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [PROD_W-1:0]       rsp_z;
  logic [ID_W-1:0]         rsp_id;
  logic [CNT_W-1:0]        op_count;
  logic                    busy;
`ifdef APPROX_MUL_EXACT_EN
  logic [NUM_REQ-1:0]      req_exact;
  logic                    rsp_exact;

  modport master (
    output req_valid, req_x, req_y, req_exact, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_id, rsp_exact, op_count, busy
  );

  modport slave (
    input  req_valid, req_x, req_y, req_exact, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_id, rsp_exact, op_count, busy
  );
`else
  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_id, op_count, busy
  );

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_id, op_count, busy
  );
`endif

endinterface

// File: rtl/approx_mul_share_ctrl_core.sv
// Combinational 8x8 -> 16 approximate multiplier (l=2 truncation).
module approx_mul8_l2_core
  import approx_mul_pkg::*;
(
  input  logic [OP_W-1:0]   i_x,
  input  logic [OP_W-1:0]   i_y,
  output logic [PROD_W-1:0] o_z_c
);

  assign o_z_c = approx_mul8_l2(i_x, i_y);

endmodule

// File: rtl/approx_mul_share_ctrl.sv
// Round-robin share of one approximate multiplier across NUM_REQ requesters, 2-stage pipe.
// Optional feature macro: APPROX_MUL_EXACT_EN (per-operation exact product select).
module approx_mul_share_ctrl
  import approx_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned CNT_W   = 16
)(
  input  logic                   clk,
  input  logic                   rst_n,
  approx_mul_share_ctrl_if.slave bus
);

  logic                w_s1_en;
  logic                w_s2_en;
  logic                w_hs;
  logic [ID_W-1:0]     w_scan_idx;
  logic [ID_W-1:0]     w_gnt_idx;
  logic [NUM_REQ-1:0]  w_gnt_oh;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [OP_W-1:0]     w_x;
  logic [OP_W-1:0]     w_y;
  logic [PROD_W-1:0]   w_core_z;
  logic [PROD_W-1:0]   w_s2_z_nxt;

  logic [ID_W-1:0]     r_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_s1_valid;
  logic [OP_W-1:0]     r_s1_x;
  logic [OP_W-1:0]     r_s1_y;
  logic [ID_W-1:0]     r_s1_id;
  logic                r_s2_valid;
  logic [PROD_W-1:0]   r_s2_z;
  logic [ID_W-1:0]     r_s2_id;
`ifdef APPROX_MUL_EXACT_EN
  logic                w_exact;
  logic                r_s1_exact;
  logic                r_s2_exact;
`endif

  assign w_s2_en = !r_s2_valid || bus.rsp_ready;
  assign w_s1_en = !r_s1_valid || w_s2_en;

  // Round-robin scan starting at r_ptr; no grants are offered while reset is held.
  always_comb begin
    w_hs       = 1'b0;
    w_gnt_idx  = '0;
    w_scan_idx = '0;
    if (rst_n && w_s1_en) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        w_scan_idx = ID_W'((32'(r_ptr) + 32'(k)) % 32'(NUM_REQ));
        if (!w_hs && bus.req_valid[w_scan_idx]) begin
          w_hs      = 1'b1;
          w_gnt_idx = w_scan_idx;
        end
      end
    end
  end

  assign w_gnt_oh      = w_hs ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign w_ptr_nxt     = (32'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + ID_W'(1);
  assign bus.req_ready = w_gnt_oh;

  // Operand select from the granted requester lane.
  always_comb begin
    w_x = '0;
    w_y = '0;
`ifdef APPROX_MUL_EXACT_EN
    w_exact = 1'b0;
`endif
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_gnt_oh[i]) begin
        w_x = bus.req_x[i*OP_W +: OP_W];
        w_y = bus.req_y[i*OP_W +: OP_W];
`ifdef APPROX_MUL_EXACT_EN
        w_exact = bus.req_exact[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_hs) begin
      r_ptr <= w_ptr_nxt;
      if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Stage 1: operand register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_id    <= '0;
`ifdef APPROX_MUL_EXACT_EN
      r_s1_exact <= 1'b0;
`endif
    end else if (w_s1_en) begin
      r_s1_valid <= w_hs;
      if (w_hs) begin
        r_s1_x  <= w_x;
        r_s1_y  <= w_y;
        r_s1_id <= w_gnt_idx;
`ifdef APPROX_MUL_EXACT_EN
        r_s1_exact <= w_exact;
`endif
      end
    end
  end

  approx_mul8_l2_core u_core (
    .i_x   (r_s1_x),
    .i_y   (r_s1_y),
    .o_z_c (w_core_z)
  );

`ifdef APPROX_MUL_EXACT_EN
  assign w_s2_z_nxt = r_s1_exact ? exact_mul8(r_s1_x, r_s1_y) : w_core_z;
`else
  assign w_s2_z_nxt = w_core_z;
`endif

  // Stage 2: result register; holds steady while the response is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_z     <= '0;
      r_s2_id    <= '0;
`ifdef APPROX_MUL_EXACT_EN
      r_s2_exact <= 1'b0;
`endif
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_z  <= w_s2_z_nxt;
        r_s2_id <= r_s1_id;
`ifdef APPROX_MUL_EXACT_EN
        r_s2_exact <= r_s1_exact;
`endif
      end
    end
  end

  assign bus.rsp_valid = r_s2_valid;
  assign bus.rsp_z     = r_s2_z;
  assign bus.rsp_id    = r_s2_id;
  assign bus.op_count  = r_cnt;
  assign bus.busy      = r_s1_valid || r_s2_valid;
`ifdef APPROX_MUL_EXACT_EN
  assign bus.rsp_exact = r_s2_exact;
`endif

endmodule

// File: tb/tb_approx_mul_share_ctrl.sv
// Directed self-checking bench for approx_mul_share_ctrl (main instance plus a CNT_W=4 instance).
module tb_approx_mul_share_ctrl;

  localparam int unsigned NR    = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SAT_W = 4;

  localparam logic [7:0]  AX [6] = '{8'd7,    8'd255,    8'd3,  8'd255,    8'd2,    8'd0};
  localparam logic [7:0]  AY [6] = '{8'd200,  8'd255,    8'd3,  8'd128,    8'd128,  8'd255};
  localparam logic [15:0] AZ [6] = '{16'd1056, 16'd64516, 16'd0, 16'd32512, 16'd256, 16'd0};
  localparam logic [7:0]  RX [4] = '{8'd8, 8'd16, 8'd24, 8'd32};
  localparam logic [15:0] RZ [4] = '{16'd80, 16'd160, 16'd240, 16'd320};

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  approx_mul_share_ctrl_if #(.NUM_REQ(NR), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();
  approx_mul_share_ctrl_if #(.NUM_REQ(NR), .ID_W(ID_W), .CNT_W(SAT_W)) bus_s ();

  approx_mul_share_ctrl #(.NUM_REQ(NR), .ID_W(ID_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  approx_mul_share_ctrl #(.NUM_REQ(NR), .ID_W(ID_W), .CNT_W(SAT_W)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    @(posedge clk); #1;
    n_vec++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready act=%b exp=0000", bus.req_ready); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid act=%b exp=0", bus.rsp_valid); end
    n_vec++; if (bus.rsp_z !== 16'd0) begin n_err++; $display("FAIL reset_rsp_z act=%0d exp=0", bus.rsp_z); end
    n_vec++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id act=%0d exp=0", bus.rsp_id); end
    n_vec++; if (bus.op_count !== 16'd0) begin n_err++; $display("FAIL reset_op_count act=%0d exp=0", bus.op_count); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy act=%b exp=0", bus.busy); end
    bus.req_valid = '0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_approx();
    for (int i = 0; i < 6; i++) begin
      bus.req_x[15:8] = AX[i];
      bus.req_y[15:8] = AY[i];
      bus.req_valid   = 4'b0010;
      #1;
      n_vec++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL approx_ready[%0d] act=%b exp=0010", i, bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = '0;
      n_vec++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL approx_latency[%0d] act=v%b/b%b exp=v0/b1", i, bus.rsp_valid, bus.busy); end
      @(posedge clk); #1;
      n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL approx_valid[%0d] act=%b exp=1", i, bus.rsp_valid); end
      n_vec++; if (bus.rsp_z !== AZ[i]) begin n_err++; $display("FAIL approx_z[%0d] act=%0d exp=%0d", i, bus.rsp_z, AZ[i]); end
      n_vec++; if (bus.rsp_id !== 2'd1) begin n_err++; $display("FAIL approx_id[%0d] act=%0d exp=1", i, bus.rsp_id); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    int         r;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      bus.req_x[8*i +: 8] = RX[i];
      bus.req_y[8*i +: 8] = 8'd10;
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) bus.req_valid = '0;
      #1;
      exp_rdy = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      n_vec++; if (bus.req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready[%0d] act=%b exp=%b", c, bus.req_ready, exp_rdy); end
      n_vec++; if (bus.op_count !== 16'((c < 8) ? c : 8)) begin n_err++; $display("FAIL rr_op_count[%0d] act=%0d exp=%0d", c, bus.op_count, (c < 8) ? c : 8); end
      if (c >= 2) begin
        r = (c - 2) % 4;
        n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(r) || bus.rsp_z !== RZ[r]) begin
          n_err++; $display("FAIL rr_rsp[%0d] act=v%b id%0d z%0d exp=v1 id%0d z%0d", c, bus.rsp_valid, bus.rsp_id, bus.rsp_z, r, RZ[r]);
        end
      end else begin
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_early_rsp[%0d] act=%b exp=0", c, bus.rsp_valid); end
      end
      @(posedge clk); #1;
    end
    n_vec++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rr_idle act=v%b b%b exp=v0 b0", bus.rsp_valid, bus.busy); end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready    = 1'b0;
    bus.req_x[7:0]   = 8'd12;
    bus.req_y[7:0]   = 8'd5;
    bus.req_valid    = 4'b0001;
    #1;
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_accept0 act=%b exp=0001", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_x[7:0] = 8'd255;
    bus.req_y[7:0] = 8'd200;
    #1;
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_accept1 act=%b exp=0001", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_x[7:0] = 8'd6;
    bus.req_y[7:0] = 8'd129;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_stall_ready[%0d] act=%b exp=0000", c, bus.req_ready); end
      n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_z !== 16'd60 || bus.rsp_id !== 2'd0 || bus.busy !== 1'b1) begin
        n_err++; $display("FAIL bp_stall_rsp[%0d] act=v%b z%0d id%0d b%b exp=v1 z60 id0 b1", c, bus.rsp_valid, bus.rsp_z, bus.rsp_id, bus.busy);
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_resume_ready act=%b exp=0001", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = '0;
    n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_z !== 16'd50656) begin n_err++; $display("FAIL bp_drain_b act=v%b z%0d exp=v1 z50656", bus.rsp_valid, bus.rsp_z); end
    @(posedge clk); #1;
    n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_z !== 16'd772) begin n_err++; $display("FAIL bp_drain_c act=v%b z%0d exp=v1 z772", bus.rsp_valid, bus.rsp_z); end
    @(posedge clk); #1;
    n_vec++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL bp_empty act=v%b b%b exp=v0 b0", bus.rsp_valid, bus.busy); end
    n_vec++; if (bus.op_count !== 16'd11) begin n_err++; $display("FAIL bp_op_count act=%0d exp=11", bus.op_count); end
  endtask

  task automatic test_mid_reset();
    bus.rsp_ready     = 1'b0;
    bus.req_x[23:16]  = 8'd9;
    bus.req_y[23:16]  = 8'd9;
    bus.req_valid     = 4'b0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++; if (bus.rsp_valid !== 1'b1 || bus.busy !== 1'b1 || bus.req_ready !== 4'b0) begin
      n_err++; $display("FAIL mr_full act=v%b b%b r%b exp=v1 b1 r0000", bus.rsp_valid, bus.busy, bus.req_ready);
    end
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL mr_clear act=v%b b%b exp=v0 b0", bus.rsp_valid, bus.busy); end
    n_vec++; if (bus.op_count !== 16'd0 || bus.rsp_z !== 16'd0) begin n_err++; $display("FAIL mr_cnt_z act=c%0d z%0d exp=c0 z0", bus.op_count, bus.rsp_z); end
    bus.req_valid = '0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL mr_first_grant act=%b exp=0001", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    bus_s.req_x[7:0] = 8'd1;
    bus_s.req_y[7:0] = 8'd1;
    bus_s.req_valid  = 4'b0001;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 14) begin
        n_vec++; if (bus_s.op_count !== 4'd14) begin n_err++; $display("FAIL sat_count14 act=%0d exp=14", bus_s.op_count); end
      end
    end
    bus_s.req_valid = '0;
    n_vec++; if (bus_s.op_count !== 4'd15) begin n_err++; $display("FAIL sat_count20 act=%0d exp=15", bus_s.op_count); end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

`ifdef APPROX_MUL_EXACT_EN
  task automatic test_exact();
    for (int e = 1; e >= 0; e--) begin
      bus.req_x[15:8]  = 8'd7;
      bus.req_y[15:8]  = 8'd200;
      bus.req_exact    = (e == 1) ? 4'b0010 : 4'b0000;
      bus.req_valid    = 4'b0010;
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(posedge clk); #1;
      n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_z !== ((e == 1) ? 16'd1400 : 16'd1056) || bus.rsp_exact !== 1'(e)) begin
        n_err++; $display("FAIL exact[%0d] act=v%b z%0d x%b exp=v1 z%0d x%0d", e, bus.rsp_valid, bus.rsp_z, bus.rsp_exact, (e == 1) ? 1400 : 1056, e);
      end
    end
    bus.req_exact = '0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst_n           = 1'b0;
    bus.req_valid   = '0;
    bus.req_x       = '0;
    bus.req_y       = '0;
    bus.rsp_ready   = 1'b1;
    bus_s.req_valid = '0;
    bus_s.req_x     = '0;
    bus_s.req_y     = '0;
    bus_s.rsp_ready = 1'b1;
`ifdef APPROX_MUL_EXACT_EN
    bus.req_exact   = '0;
    bus_s.req_exact = '0;
`endif
    test_reset();
    test_approx();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_saturation();
`ifdef APPROX_MUL_EXACT_EN
    test_exact();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/approx_mul_share_ctrl.md
Name: approx_mul_share_ctrl

Overview:
- Shares one unsigned 8x8 approximate multiplier core (l=2 truncation) among NUM_REQ requesters.
- Round-robin arbitration. Valid/ready handshakes on every requester port and on the single response port.
- Two-stage pipeline: operand register, then result register.
- Sits between the accelerator's operand queues and the accumulation logic. Tags each result with the requester index.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- ID_W, 2, width of rsp_id; equals clog2(NUM_REQ), minimum 1.
- CNT_W, 16, width of the saturating accepted-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_x  in  8*NUM_REQ  multiplicand; requester i uses bits [8i+7:8i].
- req_y  in  8*NUM_REQ  multiplier; same packing as req_x.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_z  out  16  approximate product.
- rsp_id  out  ID_W  index of the requester that owns rsp_z.
- op_count  out  CNT_W  number of accepted operations, saturating.
- busy  out  1  high when either pipeline stage holds valid data.

Behaviour:
- Reset (rst_n low, asynchronous) clears the following. Everything returns to this state when reset asserts mid-operation; in-flight operations are discarded, not replayed.
  - s1_valid and s2_valid = 0
  - rsp_valid = 0, rsp_z = 0, rsp_id = 0
  - op_count = 0
  - round-robin pointer = 0
  - req_ready = 0, busy = 0
- Core function: z = ((x>>2)*y)<<2 + ((x[1]&y[7])<<8).
  - Maximum value is 64516, so the result always fits 16 bits and no overflow handling is needed.
- Stage advance:
  - s2_en = !s2_valid | rsp_ready
  - s1_en = !s1_valid | s2_en
- Arbitration:
  - When s1_en is high, scan from pointer upward with wrap-around.
  - The first i with req_valid[i] gets req_ready[i] = 1, combinationally in the same cycle.
  - Handshake completes when req_valid[i] & req_ready[i].
  - After a grant, the pointer becomes i+1 mod NUM_REQ. With no grant, the pointer holds.
- req_ready depends on req_valid (same-cycle grant). Requesters must not make req_valid depend on req_ready.
- Stage 1: on a handshake it latches x, y and id and sets s1_valid. If s1_en is high and there is no handshake, s1_valid clears.
- Stage 2: when s2_en & s1_valid, it latches the core output and id and sets s2_valid. If s2_en is high and s1_valid is low, s2_valid clears.
- rsp_valid = s2_valid. rsp_z and rsp_id come from registers and are stable while rsp_valid & !rsp_ready.
- Latency: a handshake in cycle N gives rsp_valid in cycle N+2, provided there is no backpressure.
- Throughput: one operation per cycle while rsp_ready is high.
- Backpressure: with rsp_ready low and both stages full, all req_ready = 0. Nothing is dropped or duplicated.
- Simultaneous events:
  - A response drain, an s1→s2 move and a new grant can all happen in the same cycle.
  - All requesters valid → strict rotation 0,1,2,3,0…
- op_count increments on each handshake and saturates at all-ones.
- busy = s1_valid | s2_valid.

Optional Feature:
- Macro: APPROX_MUL_EXACT_EN.
- When defined:
  - Adds input req_exact [NUM_REQ] and output rsp_exact [1].
  - req_exact is latched with the operands.
  - Stage 2 selects x*y (exact product) when the latched bit is 1, otherwise the approximate core output.
  - rsp_exact echoes the latched bit.
- When undefined: neither port exists and the block always returns the approximate product.

Decomposition:
- Package approx_mul_pkg holds:
  - the localparam for the truncation level (L=2)
  - the default NUM_REQ
  - the function approx_mul8_l2(x,y), which is the single golden model shared by RTL and bench.
- Sub-module approx_mul8_l2_core: purely combinational, 8x8 → 16, wraps the package function, instantiated once between stage 1 and stage 2.

Test Plan:
- Approximate values: requester 1 sends x=7, y=200 → two cycles later rsp_valid=1, rsp_z=1056, rsp_id=1. Then x=255, y=255 → 64516. Then x=3, y=3 → 0.
- Round-robin: all four req_valid held high with rsp_ready=1 for 8 cycles → grants 0,1,2,3,0,1,2,3; rsp_id follows the same order two cycles later; op_count=8.
- Backpressure: rsp_ready=0 with req0 streaming → two accepts, then req_ready=0. rsp_z and rsp_id stay stable. Raising rsp_ready drains results in order with none lost.
- Mid-operation reset: rst_n pulsed low asynchronously with both stages full → rsp_valid, busy and op_count drop to 0 immediately. The next grant goes to requester 0.
- Saturation: with CNT_W=4, accept 20 operations → op_count=15.
- With APPROX_MUL_EXACT_EN defined: x=7, y=200, req_exact=1 → rsp_z=1400, rsp_exact=1. With req_exact=0 → rsp_z=1056.
